// File: rtl/max_score_collector_if.sv
// rtl/max_score_collector_if.sv - job, sample and result signals of the max-score collector
interface max_score_collector_if #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 12
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  len;
  logic                  pe_valid;
  logic [DATA_WIDTH-1:0] tree_score;
  logic                  init_o;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_score;
  logic [CNT_WIDTH-1:0]  out_idx;

  modport master (
    output start, len, pe_valid, tree_score, out_ready,
    input  init_o, busy, out_valid, out_score, out_idx
  );

  modport slave (
    input  start, len, pe_valid, tree_score, out_ready,
    output init_o, busy, out_valid, out_score, out_idx
  );
endinterface

// File: rtl/max_score_collector.sv
// rtl/max_score_collector.sv - tracks best max-tree score and its sample index over one job
module max_score_collector #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  max_score_collector_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  drain_cnt;
  logic                  v1;
  logic                  v2;
  logic [CNT_WIDTH-1:0]  idx1;
  logic [CNT_WIDTH-1:0]  idx2;
  logic [DATA_WIDTH-2:0] best_mag;
  logic [CNT_WIDTH-1:0]  best_idx;
  logic                  init_q;
  logic                  busy_q;
  logic                  out_valid_q;

  logic [DATA_WIDTH-2:0] tree_mag;
  logic                  accept;
  logic                  last_sample;
  logic                  take;

  // Negative tree results can never beat the cleared best, so they count as zero.
  always_comb begin
    tree_mag    = bus.tree_score[DATA_WIDTH-1] ? '0 : bus.tree_score[DATA_WIDTH-2:0];
    accept      = (state == RUN) && bus.pe_valid;
    last_sample = accept && (cnt == len_q - 1'b1);
    take        = v2 && (tree_mag > best_mag) && ((state == RUN) || (state == DRAIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      drain_cnt   <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      idx1        <= '0;
      idx2        <= '0;
      best_mag    <= '0;
      best_idx    <= '0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // The tree result lags its sample by two edges; this pipe keeps index and valid aligned.
      v1   <= accept;
      idx1 <= cnt;
      v2   <= v1;
      idx2 <= idx1;

      if (take) begin
        best_mag <= tree_mag;
        best_idx <= idx2;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= INIT;
            len_q    <= bus.len;
            cnt      <= '0;
            best_mag <= '0;
            best_idx <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            idx1     <= '0;
            idx2     <= '0;
            init_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        INIT: begin
          init_q <= 1'b0;
          if (len_q == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
          end
          if (last_sample) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          init_q      <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.init_o    = init_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_score = {1'b0, best_mag};
  assign bus.out_idx   = best_idx;

endmodule

// File: tb/tb_max_score_collector.sv
// tb/tb_max_score_collector.sv - table-driven and randomized checks of max_score_collector
module tb_max_score_collector;

  localparam int DW = 10;
  localparam int CW = 12;

  typedef struct {
    int              len;
    logic [15:0]     pv;
    int              npat;
    logic [3:0][9:0] sc;
    int              exp_s;
    int              exp_i;
    int              hold;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [9:0] h0;
  logic [9:0] h1;

  logic       job_pv [0:8191];
  logic [9:0] job_sc [0:8191];
  int         job_n;

  vec_t vecs [0:7];

  max_score_collector_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) ifc ();

  max_score_collector #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: inputs change at the falling edge, the max tree answers two cycles later.
  task automatic tick(input logic st, input logic pv, input logic [9:0] sc, input logic rdy);
    @(negedge clk);
    ifc.start      = st;
    ifc.pe_valid   = pv;
    ifc.out_ready  = rdy;
    ifc.tree_score = h1;
    h1 = h0;
    h0 = sc;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int len, input logic [15:0] pv, input int npat,
                              input logic [9:0] s0, input logic [9:0] s1,
                              input logic [9:0] s2, input logic [9:0] s3,
                              input int es, input int ei, input int hold);
    vec_t v;
    v.len   = len;
    v.pv    = pv;
    v.npat  = npat;
    v.sc[0] = s0;
    v.sc[1] = s1;
    v.sc[2] = s2;
    v.sc[3] = s3;
    v.exp_s = es;
    v.exp_i = ei;
    v.hold  = hold;
    return v;
  endfunction

  // Best non-negative score wins; only a strictly larger score moves the index.
  task automatic ref_model(output int bs, output int bi);
    int acc;
    int m;
    bs  = 0;
    bi  = 0;
    acc = 0;
    for (int k = 0; k < job_n; k++) begin
      if (job_pv[k]) begin
        m = job_sc[k][9] ? 0 : int'(job_sc[k][8:0]);
        if (m > bs) begin
          bs = m;
          bi = acc;
        end
        acc++;
      end
    end
  endtask

  function automatic logic [9:0] rand_score();
    case ($urandom_range(0, 3))
      0: return 10'($urandom_range(0, 1023));
      1: return 10'($urandom_range(0, 7));
      2: return 10'h200 | 10'($urandom_range(0, 511));
      default: return 10'h1FF - 10'($urandom_range(0, 2));
    endcase
  endfunction

  task automatic gen_job(input int len_v, input int pct);
    int acc;
    acc   = 0;
    job_n = 0;
    while (acc < len_v) begin
      job_pv[job_n] = ($urandom_range(0, 99) < pct);
      job_sc[job_n] = rand_score();
      if (job_pv[job_n]) acc++;
      job_n++;
    end
  endtask

  task automatic run_job(input int len_v, input int exp_s, input int exp_i, input int hold);
    logic st;
    ifc.len = CW'(len_v);
    tick(1'b1, 1'b1, 10'h1FF, 1'b0);
    chk("init_o_in_init", ifc.init_o, 1);
    chk("busy_in_init", ifc.busy, 1);
    chk("out_valid_in_init", ifc.out_valid, 0);
    tick(1'b0, 1'b1, 10'h1FF, 1'b0);
    chk("init_o_after_init", ifc.init_o, 0);
    if (len_v != 0) begin
      for (int k = 0; k < job_n; k++) begin
        st = !job_pv[k] && ($urandom_range(0, 1) == 1);
        tick(st, job_pv[k], job_sc[k], 1'b0);
      end
      chk("out_valid_edge0", ifc.out_valid, 0);
      chk("busy_drain", ifc.busy, 1);
      tick(1'b0, 1'b1, 10'h1FF, 1'b0);
      chk("out_valid_edge1", ifc.out_valid, 0);
      tick(1'b0, 1'b1, 10'h1FF, 1'b0);
    end
    chk("out_valid_done", ifc.out_valid, 1);
    chk("out_score", ifc.out_score, exp_s);
    chk("out_idx", ifc.out_idx, exp_i);
    for (int h = 0; h < hold; h++) begin
      tick(h[0], 1'b1, rand_score(), 1'b0);
      chk("hold_out_valid", ifc.out_valid, 1);
      chk("hold_out_score", ifc.out_score, exp_s);
      chk("hold_out_idx", ifc.out_idx, exp_i);
    end
    tick(1'b0, 1'b0, 10'h000, 1'b1);
    chk("out_valid_after_ready", ifc.out_valid, 0);
    chk("busy_after_ready", ifc.busy, 0);
    tick(1'b0, 1'b0, 10'h000, 1'b0);
    chk("idle_stays_idle", ifc.busy, 0);
  endtask

  initial begin
    int acc;
    int bs;
    int bi;
    int len_v;
    logic any_ov;

    n_checks       = 0;
    n_errors       = 0;
    h0             = '0;
    h1             = '0;
    ifc.start      = 1'b0;
    ifc.len        = '0;
    ifc.pe_valid   = 1'b0;
    ifc.tree_score = '0;
    ifc.out_ready  = 1'b0;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_init_o", ifc.init_o, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_score", ifc.out_score, 0);
    chk("rst_out_idx", ifc.out_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = mk(4, 16'b1111,   4, 10'd5,    10'd9,    10'd3,    10'd9, 9,   1, 1);
    vecs[1] = mk(3, 16'b101001, 6, 10'd7,    10'd12,   10'd4,    10'd0, 12,  1, 5);
    vecs[2] = mk(2, 16'b11,     2, 10'h205,  10'h003,  10'd0,    10'd0, 3,   1, 0);
    vecs[3] = mk(0, 16'b0,      0, 10'd0,    10'd0,    10'd0,    10'd0, 0,   0, 2);
    vecs[4] = mk(3, 16'b111,    3, 10'h3FF,  10'h200,  10'h201,  10'd0, 0,   0, 0);
    vecs[5] = mk(1, 16'b1,      1, 10'h1FF,  10'd0,    10'd0,    10'd0, 511, 0, 0);
    vecs[6] = mk(3, 16'b1101,   4, 10'd6,    10'd6,    10'd2,    10'd0, 6,   0, 0);
    vecs[7] = mk(3, 16'b111,    3, 10'd1,    10'd2,    10'd3,    10'd0, 3,   2, 1);

    for (int v = 0; v < 8; v++) begin
      acc   = 0;
      job_n = vecs[v].npat;
      for (int k = 0; k < vecs[v].npat; k++) begin
        job_pv[k] = vecs[v].pv[k];
        if (vecs[v].pv[k]) begin
          job_sc[k] = vecs[v].sc[acc];
          acc++;
        end else begin
          job_sc[k] = 10'h1FF;
        end
      end
      run_job(vecs[v].len, vecs[v].exp_s, vecs[v].exp_i, vecs[v].hold);
    end

    for (int r = 0; r < 40; r++) begin
      len_v = (r % 10 == 9) ? 0 : int'($urandom_range(1, 24));
      gen_job(len_v, int'($urandom_range(30, 100)));
      ref_model(bs, bi);
      run_job(len_v, bs, bi, int'($urandom_range(0, 3)));
    end

    gen_job(4095, 100);
    ref_model(bs, bi);
    run_job(4095, bs, bi, 1);

    // Reset during RUN after two accepted samples of eight.
    ifc.len = CW'(8);
    tick(1'b1, 1'b0, 10'd0, 1'b0);
    tick(1'b0, 1'b0, 10'd0, 1'b0);
    tick(1'b0, 1'b1, 10'd50, 1'b0);
    tick(1'b0, 1'b1, 10'd60, 1'b0);
    chk("busy_before_reset", ifc.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_init_o", ifc.init_o, 0);
    chk("midrst_busy", ifc.busy, 0);
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_out_score", ifc.out_score, 0);
    chk("midrst_out_idx", ifc.out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_ov = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1, 10'd100, 1'b1);
      any_ov = any_ov | ifc.out_valid | ifc.busy;
    end
    chk("no_result_after_reset", any_ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
